// File: rtl/text_ram_arbiter_if.sv
// Bus bundle between the character-RAM arbiter and its surroundings.
//   vid_active           : visible-area flag from the video timing
//   req/addr/data/gnt 0,1: write-request handshakes (loader, host/UART)
//   clr_req/clr_done     : clear-screen request pulse and completion pulse
//   busy                 : clear in progress or pending
//   ram_we/addr/wdata    : character RAM write port
//   addr_err             : granted address was outside the screen
// master = requester/timing side, slave = arbiter.
interface text_ram_arbiter_if;
  logic        vid_active;
  logic        req0;
  logic [11:0] addr0;
  logic [7:0]  data0;
  logic        gnt0;
  logic        req1;
  logic [11:0] addr1;
  logic [7:0]  data1;
  logic        gnt1;
  logic        clr_req;
  logic        clr_done;
  logic        busy;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        addr_err;

  modport master (
    output vid_active, req0, addr0, data0, req1, addr1, data1, clr_req,
    input  gnt0, gnt1, clr_done, busy, ram_we, ram_addr, ram_wdata, addr_err
  );

  modport slave (
    input  vid_active, req0, addr0, data0, req1, addr1, data1, clr_req,
    output gnt0, gnt1, clr_done, busy, ram_we, ram_addr, ram_wdata, addr_err
  );
endinterface

// File: rtl/text_ram_arbiter.sv
// Character RAM write arbiter for a text-mode display.
// Two requesters share the RAM write port under round-robin arbitration;
// writes are only issued outside active video. A clear-screen request
// fills every cell with BLANK_CHAR, taking priority over requesters.
// Ports: clk, rst (async, active-high), bus (text_ram_arbiter_if.slave).
// All outputs are registered.
module text_ram_arbiter #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 rst,
  text_ram_arbiter_if.slave    bus
);

  localparam int          NCELL     = COLS * ROWS;
  localparam logic [11:0] LAST_ADDR = 12'(NCELL - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state, state_n;
  logic        clr_pending, clr_pending_n;
  logic [11:0] cnt, cnt_n;
  logic        last_gnt, last_gnt_n;   // 1: requester 1 was granted last

  logic        gnt0_p1, gnt0_n;
  logic        gnt1_p1, gnt1_n;
  logic        we_p1, we_n;
  logic [11:0] addr_p1, addr_n;
  logic [7:0]  wdata_p1, wdata_n;
  logic        done_p1, done_n;
  logic        busy_p1, busy_n;
  logic        err_p1, err_n;

  logic        elig0, elig1, sel1, in_range;
  logic [11:0] sel_addr;
  logic [7:0]  sel_data;

  // Next-state and output decode
  always_comb begin
    state_n       = state;
    clr_pending_n = clr_pending;
    cnt_n         = cnt;
    last_gnt_n    = last_gnt;
    gnt0_n        = 1'b0;
    gnt1_n        = 1'b0;
    we_n          = 1'b0;
    addr_n        = addr_p1;
    wdata_n       = wdata_p1;
    done_n        = 1'b0;
    err_n         = 1'b0;

    // A requester whose grant is showing this cycle is not eligible,
    // which also prevents back-to-back grants to the same requester.
    elig0    = bus.req0 && !gnt0_p1;
    elig1    = bus.req1 && !gnt1_p1;
    sel1     = elig1 && (!elig0 || !last_gnt);
    sel_addr = sel1 ? bus.addr1 : bus.addr0;
    sel_data = sel1 ? bus.data1 : bus.data0;
    in_range = int'(sel_addr) < NCELL;

    unique case (state)
      IDLE: begin
        if (clr_pending) begin
          state_n       = CLEAR;
          cnt_n         = '0;
          clr_pending_n = 1'b0;
        end else if (bus.clr_req) begin
          // Clear wins over a same-cycle write request.
          clr_pending_n = 1'b1;
        end else if (!bus.vid_active && (elig0 || elig1)) begin
          gnt0_n     = !sel1;
          gnt1_n     = sel1;
          addr_n     = sel_addr;
          wdata_n    = sel_data;
          we_n       = in_range;
          err_n      = !in_range;
          last_gnt_n = sel1;
        end
      end
      CLEAR: begin
        // clr_req is deliberately ignored here: no restart, no second done.
        if (!bus.vid_active) begin
          we_n    = 1'b1;
          addr_n  = cnt;
          wdata_n = BLANK_CHAR;
          cnt_n   = cnt + 12'd1;
          if (cnt == LAST_ADDR) begin
            state_n = IDLE;
            done_n  = 1'b1;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == CLEAR) || clr_pending_n;
  end

  // Stage p1: control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clr_pending <= 1'b0;
      cnt         <= '0;
      last_gnt    <= 1'b1;
      gnt0_p1     <= 1'b0;
      gnt1_p1     <= 1'b0;
      we_p1       <= 1'b0;
      addr_p1     <= '0;
      wdata_p1    <= '0;
      done_p1     <= 1'b0;
      busy_p1     <= 1'b0;
      err_p1      <= 1'b0;
    end else begin
      state       <= state_n;
      clr_pending <= clr_pending_n;
      cnt         <= cnt_n;
      last_gnt    <= last_gnt_n;
      gnt0_p1     <= gnt0_n;
      gnt1_p1     <= gnt1_n;
      we_p1       <= we_n;
      addr_p1     <= addr_n;
      wdata_p1    <= wdata_n;
      done_p1     <= done_n;
      busy_p1     <= busy_n;
      err_p1      <= err_n;
    end
  end

  assign bus.gnt0      = gnt0_p1;
  assign bus.gnt1      = gnt1_p1;
  assign bus.ram_we    = we_p1;
  assign bus.ram_addr  = addr_p1;
  assign bus.ram_wdata = wdata_p1;
  assign bus.clr_done  = done_p1;
  assign bus.busy      = busy_p1;
  assign bus.addr_err  = err_p1;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter: table of single-cycle vectors
// followed by hand-written clear and reset-mid-clear sequences.
module tb_text_ram_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  text_ram_arbiter_if bus();

  text_ram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vid;
    logic        r0;
    logic [11:0] a0;
    logic [7:0]  d0;
    logic        r1;
    logic [11:0] a1;
    logic [7:0]  d1;
    logic        clr;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[20];

  // Observed outputs: {gnt0,gnt1,we,err,busy,done,addr[11:0],wdata[7:0]}
  function automatic logic [25:0] obs();
    return {bus.gnt0, bus.gnt1, bus.ram_we, bus.addr_err, bus.busy,
            bus.clr_done, bus.ram_addr, bus.ram_wdata};
  endfunction

  function automatic logic [25:0] e(logic g0, logic g1, logic we, logic er,
                                    logic bz, logic dn, logic [11:0] ad,
                                    logic [7:0] wd);
    return {g0, g1, we, er, bz, dn, ad, wd};
  endfunction

  function automatic vec_t v(logic vid, logic r0, logic [11:0] a0, logic [7:0] d0,
                             logic r1, logic [11:0] a1, logic [7:0] d1,
                             logic clr, logic [25:0] ex);
    vec_t t;
    t.vid = vid; t.r0 = r0; t.a0 = a0; t.d0 = d0;
    t.r1 = r1; t.a1 = a1; t.d1 = d1; t.clr = clr; t.exp = ex;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vid, input logic r0, input logic [11:0] a0,
                       input logic [7:0] d0, input logic r1, input logic [11:0] a1,
                       input logic [7:0] d1, input logic clr);
    bus.vid_active = vid;
    bus.req0 = r0; bus.addr0 = a0; bus.data0 = d0;
    bus.req1 = r1; bus.addr1 = a1; bus.data1 = d1;
    bus.clr_req = clr;
  endtask

  initial begin
    int          exp_addr;
    logic        vid;
    logic [25:0] ex;

    checks = 0;
    failures = 0;

    // Round-robin from reset: req0 wins the first tie, then grants alternate.
    tbl[0]  = v(0, 1, 10, 8'h30, 1, 20, 8'h31, 0, e(1,0,1,0,0,0, 10, 8'h30));
    tbl[1]  = v(0, 1, 11, 8'h32, 1, 20, 8'h31, 0, e(0,1,1,0,0,0, 20, 8'h31));
    tbl[2]  = v(0, 1, 11, 8'h32, 1, 21, 8'h33, 0, e(1,0,1,0,0,0, 11, 8'h32));
    tbl[3]  = v(0, 1, 12, 8'h34, 1, 21, 8'h33, 0, e(0,1,1,0,0,0, 21, 8'h33));
    tbl[4]  = v(0, 1, 12, 8'h34, 1, 22, 8'h35, 0, e(1,0,1,0,0,0, 12, 8'h34));
    tbl[5]  = v(0, 0, 0,  8'h00, 1, 22, 8'h35, 0, e(0,1,1,0,0,0, 22, 8'h35));
    tbl[6]  = v(0, 0, 0,  8'h00, 0, 0,  8'h00, 0, e(0,0,0,0,0,0, 22, 8'h35));
    // Single write, exactly one pulse.
    tbl[7]  = v(0, 1, 5,  8'h41, 0, 0,  8'h00, 0, e(1,0,1,0,0,0, 5, 8'h41));
    tbl[8]  = v(0, 0, 0,  8'h00, 0, 0,  8'h00, 0, e(0,0,0,0,0,0, 5, 8'h41));
    tbl[9]  = v(0, 0, 0,  8'h00, 0, 0,  8'h00, 0, e(0,0,0,0,0,0, 5, 8'h41));
    // Video gating: request waits until vid_active falls.
    tbl[10] = v(1, 0, 0,  8'h00, 1, 100, 8'h42, 0, e(0,0,0,0,0,0, 5, 8'h41));
    tbl[11] = v(1, 0, 0,  8'h00, 1, 100, 8'h42, 0, e(0,0,0,0,0,0, 5, 8'h41));
    tbl[12] = v(0, 0, 0,  8'h00, 1, 100, 8'h42, 0, e(0,1,1,0,0,0, 100, 8'h42));
    tbl[13] = v(0, 0, 0,  8'h00, 0, 0,  8'h00, 0, e(0,0,0,0,0,0, 100, 8'h42));
    // Address range boundaries.
    tbl[14] = v(0, 1, 2400, 8'h55, 0, 0, 8'h00, 0, e(1,0,0,1,0,0, 2400, 8'h55));
    tbl[15] = v(0, 0, 0,  8'h00, 0, 0,  8'h00, 0, e(0,0,0,0,0,0, 2400, 8'h55));
    tbl[16] = v(0, 1, 2399, 8'h56, 0, 0, 8'h00, 0, e(1,0,1,0,0,0, 2399, 8'h56));
    tbl[17] = v(0, 0, 0,  8'h00, 0, 0,  8'h00, 0, e(0,0,0,0,0,0, 2399, 8'h56));
    tbl[18] = v(0, 0, 0,  8'h00, 1, 4095, 8'h57, 0, e(0,1,0,1,0,0, 4095, 8'h57));
    tbl[19] = v(0, 0, 0,  8'h00, 0, 0,  8'h00, 0, e(0,0,0,0,0,0, 4095, 8'h57));

    // Reset
    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    step();
    step();
    check("reset_state", 32'(obs()), 32'(26'd0));
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].vid, tbl[i].r0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].a1, tbl[i].d1, tbl[i].clr);
      step();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
    end

    // Full clear with a simultaneous req0 that must wait for clr_done.
    drive(0, 1, 7, 8'h61, 0, 0, 8'h00, 1);
    step();
    check("clr_accept", 32'(obs()), 32'(e(0,0,0,0,1,0, 4095, 8'h57)));
    bus.clr_req = 1'b0;
    step();
    check("clr_enter", 32'(obs()), 32'(e(0,0,0,0,1,0, 4095, 8'h57)));
    exp_addr = 0;
    for (int i = 0; i < 3000 && exp_addr < 2400; i++) begin
      vid = (i >= 500 && i < 503);
      bus.vid_active = vid;
      bus.clr_req = (i == 1000);
      step();
      if (!vid) begin
        ex = e(0,0,1,0, exp_addr != 2399, exp_addr == 2399, 12'(exp_addr), 8'h20);
        exp_addr++;
      end else begin
        ex = e(0,0,0,0,1,0, 12'(exp_addr - 1), 8'h20);
      end
      check($sformatf("clr_cyc%0d", i), 32'(obs()), 32'(ex));
    end
    check("clr_count", 32'(exp_addr), 32'd2400);
    bus.vid_active = 1'b0;
    bus.clr_req = 1'b0;
    step();
    check("post_clr_gnt", 32'(obs()), 32'(e(1,0,1,0,0,0, 7, 8'h61)));
    bus.req0 = 1'b0;
    step();
    check("post_clr_idle", 32'(obs()), 32'(e(0,0,0,0,0,0, 7, 8'h61)));

    // Reset in the middle of a clear.
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    step();
    for (int i = 0; i < 1001; i++) step();
    check("mid_clr_addr", 32'(obs()), 32'(e(0,0,1,0,1,0, 1000, 8'h20)));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 32'(obs()), 32'(26'd0));
    step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      check($sformatf("after_rst%0d", i), 32'(obs()), 32'(26'd0));
    end
    bus.clr_req = 1'b1;
    step();
    check("reclr_accept", 32'(obs()), 32'(e(0,0,0,0,1,0, 0, 8'h00)));
    bus.clr_req = 1'b0;
    step();
    check("reclr_enter", 32'(obs()), 32'(e(0,0,0,0,1,0, 0, 8'h00)));
    step();
    check("reclr_addr0", 32'(obs()), 32'(e(0,0,1,0,1,0, 0, 8'h20)));
    step();
    check("reclr_addr1", 32'(obs()), 32'(e(0,0,1,0,1,0, 1, 8'h20)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_ram_arbiter.md
TEXT_RAM_ARBITER -- requirements
Module: text_ram_arbiter

Interface
REQ-001 Parameters SHALL be: COLS, default 80, character columns; ROWS, default 30, character rows; BLANK_CHAR, default 8'h20, fill code used by clear.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  pixel clock (25 MHz).
- rst  in  1  reset; one clock, asynchronous and active-high.
- vid_active  in  1  high during the visible pixel area.
- req0  in  1  write request, requester 0 (message loader).
- addr0  in  12  cell address, requester 0.
- data0  in  8  character code, requester 0.
- gnt0  out  1  one-cycle grant pulse, requester 0.
- req1, addr1, data1, gnt1  same as requester 0, for requester 1 (host/UART).
- clr_req  in  1  one-cycle clear-screen request pulse.
- clr_done  out  1  one-cycle pulse when a clear finishes.
- busy  out  1  high while in CLEAR or while a clear is pending.
- ram_we  out  1  character RAM write enable.
- ram_addr  out  12  character RAM write address.
- ram_wdata  out  8  character RAM write data.
- addr_err  out  1  one-cycle pulse: the granted address was out of range.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 NCELL SHALL equal COLS*ROWS (2400 at defaults); valid addresses are 0..NCELL-1.
REQ-005 Write window: no write (ram_we=1) SHALL occur in a cycle following a cycle with vid_active=1.
- Eligibility is sampled at cycle N with vid_active=0; the write occurs at cycle N+1.
REQ-006 FSM states SHALL be IDLE and CLEAR.
REQ-007 IDLE grant rule: in IDLE with vid_active=0 and no clear pending, the block SHALL pick one eligible requester.
- Requester i is eligible if req_i=1 and gnt_i=0 in that cycle.
REQ-008 Round-robin: if both are eligible, the block SHALL grant the requester not granted last; the last-granted pointer resets to 1, so req0 wins the first tie.
REQ-009 Grant cycle (next cycle), the block SHALL assert:
- gnt_i=1 for exactly one cycle;
- ram_addr=addr_i, ram_wdata=data_i;
- ram_we=1 only if addr_i<NCELL; otherwise ram_we=0 and addr_err=1.
REQ-010 Requester protocol: a requester SHALL hold req, addr and data stable until it sees gnt; it may deassert req or present the next request in the cycle after gnt.
REQ-011 Throughput: no requester SHALL receive grants in consecutive cycles; at most one write per cycle overall.
REQ-012 Clear pending: clr_req=1 SHALL set clr_pending; busy SHALL be high from the next cycle.
REQ-013 Clear entry: from IDLE with clr_pending=1, the block SHALL:
- enter CLEAR on the next edge;
- set the clear counter to 0 and clear clr_pending;
- issue no new grant in that cycle; a grant already issued completes normally.
REQ-014 CLEAR: each cycle with vid_active=0, the block SHALL write ram_addr=counter, ram_wdata=BLANK_CHAR, ram_we=1, then increment the counter; during active video the counter SHALL hold.
REQ-015 Clear exit: after writing address NCELL-1, the block SHALL pulse clr_done for one cycle and return to IDLE; busy SHALL drop that same cycle unless a new clr_req arrived.
REQ-016 During CLEAR, the block SHALL:
- issue no gnt0/gnt1; requests are held off, not lost;
- ignore clr_req (no restart, no second clr_done).
REQ-017 Simultaneity: clr_req and req_i in the same IDLE cycle SHALL give priority to the clear; req_i is granted after clr_done.

Reset
REQ-018 rst=1 SHALL asynchronously force:
- state=IDLE, clr_pending=0, counter=0, RR pointer=1;
- gnt0=gnt1=0, ram_we=0, ram_addr=0, ram_wdata=0, clr_done=0, busy=0, addr_err=0.
REQ-019 Reset mid-CLEAR SHALL abort the clear with no clr_done; after release, operation SHALL resume from IDLE.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Single write: vid_active=0, req0=1, addr0=5, data0=8'h41 -> next cycle gnt0=1, ram_we=1, ram_addr=5, ram_wdata=8'h41; exactly one pulse.
- Round-robin: req0 and req1 held high in blanking -> grants alternate gnt0,gnt1,gnt0,... starting with gnt0; never two gnt on one requester in consecutive cycles.
- Video gating: req1 asserted with vid_active=1 -> no gnt1, ram_we=0 until the cycle after vid_active falls.
- Out of range: addr0=2400 -> gnt0=1, addr_err=1, ram_we=0.
- Clear: clr_req pulse with vid_active=0 throughout -> 2400 writes of 8'h20 at addresses 0..2399, then clr_done for one cycle, busy drops; a req0 held during the clear is granted after clr_done.
- Reset mid-clear: rst at counter=1000 -> all outputs 0 immediately; no clr_done; a fresh clr_req restarts from address 0.
